imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/fetch_pkg.sv | 7 +
 rtl/arb_wait_counter.sv | 26 ++
 rtl/imem_arbiter.sv | 100 ++++++++++
 tb/tb_imem_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction-memory arbiter.
package fetch_pkg;
    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} arb_state_t;

    localparam int IMEM_DEPTH = 256;
    localparam int IMEM_IDX_W = 8;
endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles a fetch request has been refused.
// Latency: count updates on the clock edge following the refused cycle.
// Backpressure: none; the count only steers arbitration priority.
module arb_wait_counter #(
    parameter logic [3:0] MAX_WAIT = 4'd4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       fetch_req,
    input  logic       fetch_gnt,
    output logic [3:0] wait_cnt,
    output logic       wait_max
);
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt <= 4'd0;
        end else if (fetch_req && !fetch_gnt) begin
            if (wait_cnt != MAX_WAIT)
                wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    assign wait_max = (wait_cnt == MAX_WAIT);
endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: loader-only BOOT phase, then fetch/loader sharing in RUN.
// Latency: grants are combinational in the request cycle; Fetch_Valid/Fetch_Data follow one cycle later.
// Backpressure: a refused requester holds its request; IMEM_ARB_STARVE_EN bounds fetch starvation by MAX_WAIT.
module imem_arbiter
    import fetch_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  Fetch_Req,
    input  logic [31:0]           Fetch_Addr,
    output logic                  Fetch_Gnt,
    output logic                  Fetch_Valid,
    output logic [31:0]           Fetch_Data,
    input  logic                  Load_Req,
    input  logic [31:0]           Load_Addr,
    input  logic [31:0]           Load_Data,
    output logic                  Load_Gnt,
    input  logic                  Load_Done,
    output logic                  Mem_En,
    output logic                  Mem_We,
    output logic [IMEM_IDX_W-1:0] Mem_Addr,
    output logic [31:0]           Mem_Wdata,
    input  logic [31:0]           Mem_Rdata,
    output logic                  Run
);
    arb_state_t  state;
    logic        rst_done;
    logic        rd_pend;
    logic [31:0] data_q;
    logic        fetch_gnt;
    logic        load_gnt;
    logic        fetch_pri;

`ifdef IMEM_ARB_STARVE_EN
    logic [3:0] wait_cnt;

    arb_wait_counter #(
        .MAX_WAIT (4'(MAX_WAIT))
    ) u_wait (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .fetch_req (Fetch_Req),
        .fetch_gnt (fetch_gnt),
        .wait_cnt  (wait_cnt),
        .wait_max  (fetch_pri)
    );
`else
    logic [31:0] unused_max_wait;
    assign unused_max_wait = 32'(MAX_WAIT);
    assign fetch_pri = 1'b0;
`endif

    // rst_done keeps every grant off until the first clock edge after reset release.
    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (rst_done) begin
            if (state == BOOT)
                load_gnt = Load_Req;
            else if (Load_Req && !(Fetch_Req && fetch_pri))
                load_gnt = 1'b1;
            else
                fetch_gnt = Fetch_Req;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= BOOT;
            rst_done <= 1'b0;
            rd_pend  <= 1'b0;
            data_q   <= 32'd0;
        end else begin
            rst_done <= 1'b1;
            rd_pend  <= fetch_gnt;
            if (rd_pend)
                data_q <= Mem_Rdata;
            if (state == BOOT && rst_done && Load_Done)
                state <= RUN;
        end
    end

    logic [21:0] unused_addr_hi;
    logic [3:0]  unused_addr_lo;
    assign unused_addr_hi = Fetch_Addr[31:10] ^ Load_Addr[31:10];
    assign unused_addr_lo = {Fetch_Addr[1:0], Load_Addr[1:0]};

    assign Fetch_Gnt   = fetch_gnt;
    assign Load_Gnt    = load_gnt;
    assign Mem_En      = fetch_gnt | load_gnt;
    assign Mem_We      = load_gnt;
    assign Mem_Addr    = load_gnt  ? Load_Addr[IMEM_IDX_W+1:2]  :
                         fetch_gnt ? Fetch_Addr[IMEM_IDX_W+1:2] : '0;
    assign Mem_Wdata   = load_gnt ? Load_Data : 32'd0;
    assign Fetch_Valid = rd_pend;
    assign Fetch_Data  = rd_pend ? Mem_Rdata : data_q;
    assign Run         = (state == RUN);
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed vector bench for imem_arbiter with a behavioural synchronous memory.
module tb_imem_arbiter;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        Fetch_Req;
    logic [31:0] Fetch_Addr;
    logic        Fetch_Gnt;
    logic        Fetch_Valid;
    logic [31:0] Fetch_Data;
    logic        Load_Req;
    logic [31:0] Load_Addr;
    logic [31:0] Load_Data;
    logic        Load_Gnt;
    logic        Load_Done;
    logic        Mem_En;
    logic        Mem_We;
    logic [7:0]  Mem_Addr;
    logic [31:0] Mem_Wdata;
    logic [31:0] Mem_Rdata;
    logic        Run;

    int checks = 0;
    int errors = 0;

    imem_arbiter #(.MAX_WAIT(4)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .Fetch_Req   (Fetch_Req),
        .Fetch_Addr  (Fetch_Addr),
        .Fetch_Gnt   (Fetch_Gnt),
        .Fetch_Valid (Fetch_Valid),
        .Fetch_Data  (Fetch_Data),
        .Load_Req    (Load_Req),
        .Load_Addr   (Load_Addr),
        .Load_Data   (Load_Data),
        .Load_Gnt    (Load_Gnt),
        .Load_Done   (Load_Done),
        .Mem_En      (Mem_En),
        .Mem_We      (Mem_We),
        .Mem_Addr    (Mem_Addr),
        .Mem_Wdata   (Mem_Wdata),
        .Mem_Rdata   (Mem_Rdata),
        .Run         (Run)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        Mem_Rdata = 32'd0;
    end
    always @(posedge CLK) begin
        if (Mem_En && Mem_We) mem[Mem_Addr] <= Mem_Wdata;
        if (Mem_En && !Mem_We) Mem_Rdata <= mem[Mem_Addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        freq;
        logic [31:0] faddr;
        logic        lreq;
        logic [31:0] laddr;
        logic [31:0] ldata;
        logic        ldone;
        logic        e_fg;
        logic        e_lg;
        logic [7:0]  e_addr;
        logic        e_run;
        logic        e_vld;
        logic [31:0] e_dat;
    } vec_t;

    function automatic vec_t mk(input logic freq, input logic [31:0] faddr,
                                input logic lreq, input logic [31:0] laddr,
                                input logic [31:0] ldata, input logic ldone,
                                input logic e_fg, input logic e_lg, input logic [7:0] e_addr,
                                input logic e_run, input logic e_vld, input logic [31:0] e_dat);
        vec_t v;
        v = {freq, faddr, lreq, laddr, ldata, ldone, e_fg, e_lg, e_addr, e_run, e_vld, e_dat};
        return v;
    endfunction

    vec_t tbl [11];
    logic exp_f;

    initial begin
        //            freq faddr         lreq laddr         ldata         done fg lg addr  run vld data
        tbl[0]  = mk(1, 32'h0000_0004, 1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 0, 1, 8'h01, 0, 0, 32'h0);
        tbl[1]  = mk(1, 32'h0000_0004, 1, 32'hFFFF_F008, 32'h1234_5678, 0, 0, 1, 8'h02, 0, 0, 32'h0);
        tbl[2]  = mk(1, 32'h0000_0004, 0, 32'h0,         32'h0,         0, 0, 0, 8'h00, 0, 0, 32'h0);
        tbl[3]  = mk(0, 32'h0,         1, 32'h0000_000C, 32'hCAFE_F00D, 1, 0, 1, 8'h03, 0, 0, 32'h0);
        tbl[4]  = mk(1, 32'h0000_0004, 0, 32'h0,         32'h0,         0, 1, 0, 8'h01, 1, 0, 32'h0);
        tbl[5]  = mk(1, 32'h0000_0404, 0, 32'h0,         32'h0,         0, 1, 0, 8'h01, 1, 1, 32'hDEAD_BEEF);
        tbl[6]  = mk(1, 32'h0000_0009, 0, 32'h0,         32'h0,         0, 1, 0, 8'h02, 1, 1, 32'hDEAD_BEEF);
        tbl[7]  = mk(0, 32'h0,         0, 32'h0,         32'h0,         0, 0, 0, 8'h00, 1, 1, 32'h1234_5678);
        tbl[8]  = mk(0, 32'h0,         0, 32'h0,         32'h0,         0, 0, 0, 8'h00, 1, 0, 32'h1234_5678);
        tbl[9]  = mk(1, 32'h0000_000C, 0, 32'h0,         32'h0,         0, 1, 0, 8'h03, 1, 0, 32'h1234_5678);
        tbl[10] = mk(0, 32'h0,         1, 32'h0000_0010, 32'h0000_0055, 0, 0, 1, 8'h04, 1, 1, 32'hCAFE_F00D);

        RST_N = 1'b0;
        Fetch_Req = 1'b1; Fetch_Addr = 32'h4;
        Load_Req = 1'b1; Load_Addr = 32'h4; Load_Data = 32'hDEAD_BEEF; Load_Done = 1'b0;

        @(negedge CLK);
        check("rst_load_gnt", 32'(Load_Gnt), 32'd0);
        check("rst_fetch_gnt", 32'(Fetch_Gnt), 32'd0);
        check("rst_mem_en", 32'(Mem_En), 32'd0);
        check("rst_run", 32'(Run), 32'd0);
        check("rst_fetch_valid", 32'(Fetch_Valid), 32'd0);
        check("rst_fetch_data", Fetch_Data, 32'd0);

        @(posedge CLK); #1 RST_N = 1'b1;
        @(negedge CLK);
        check("no_gnt_before_edge", 32'(Load_Gnt), 32'd0);

        for (int i = 0; i < 11; i++) begin
            @(posedge CLK); #1;
            Fetch_Req = tbl[i].freq; Fetch_Addr = tbl[i].faddr;
            Load_Req = tbl[i].lreq; Load_Addr = tbl[i].laddr;
            Load_Data = tbl[i].ldata; Load_Done = tbl[i].ldone;
            @(negedge CLK);
            check($sformatf("v%0d_fetch_gnt", i), 32'(Fetch_Gnt), 32'(tbl[i].e_fg));
            check($sformatf("v%0d_load_gnt", i), 32'(Load_Gnt), 32'(tbl[i].e_lg));
            check($sformatf("v%0d_mem_en", i), 32'(Mem_En), 32'(tbl[i].e_fg | tbl[i].e_lg));
            check($sformatf("v%0d_mem_we", i), 32'(Mem_We), 32'(tbl[i].e_lg));
            check($sformatf("v%0d_mem_addr", i), 32'(Mem_Addr), 32'(tbl[i].e_addr));
            if (tbl[i].e_lg)
                check($sformatf("v%0d_mem_wdata", i), Mem_Wdata, tbl[i].ldata);
            check($sformatf("v%0d_run", i), 32'(Run), 32'(tbl[i].e_run));
            check($sformatf("v%0d_fetch_valid", i), 32'(Fetch_Valid), 32'(tbl[i].e_vld));
            check($sformatf("v%0d_fetch_data", i), Fetch_Data, tbl[i].e_dat);
        end
        Load_Done = 1'b0;

        // Both requesters held: fetch only breaks through when starvation guard is built in.
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            Fetch_Req = 1'b1; Fetch_Addr = 32'h4;
            Load_Req = 1'b1; Load_Addr = 32'h20; Load_Data = 32'h0000_0077;
            @(negedge CLK);
`ifdef IMEM_ARB_STARVE_EN
            exp_f = ((i % 5) == 4);
`else
            exp_f = 1'b0;
`endif
            check($sformatf("cont%0d_fetch_gnt", i), 32'(Fetch_Gnt), 32'(exp_f));
            check($sformatf("cont%0d_load_gnt", i), 32'(Load_Gnt), 32'(!exp_f));
            check($sformatf("cont%0d_mem_we", i), 32'(Mem_We), 32'(!exp_f));
        end

        @(posedge CLK); #1;
        Load_Req = 1'b0; Fetch_Req = 1'b1; Fetch_Addr = 32'h4;
        @(negedge CLK);
        check("pre_rst_fetch_gnt", 32'(Fetch_Gnt), 32'd1);
        @(posedge CLK); #1 RST_N = 1'b0;
        #1;
        check("rst_inflight_valid_now", 32'(Fetch_Valid), 32'd0);
        @(negedge CLK);
        check("rst_inflight_valid", 32'(Fetch_Valid), 32'd0);
        check("rst_inflight_data", Fetch_Data, 32'd0);
        check("rst_inflight_run", 32'(Run), 32'd0);
        check("rst_inflight_gnt", 32'(Fetch_Gnt), 32'd0);
        @(posedge CLK); #1 RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("boot_again%0d_fetch_gnt", i), 32'(Fetch_Gnt), 32'd0);
            check($sformatf("boot_again%0d_valid", i), 32'(Fetch_Valid), 32'd0);
        end
        @(posedge CLK); #1 Load_Done = 1'b1;
        @(negedge CLK);
        check("done_cycle_fetch_gnt", 32'(Fetch_Gnt), 32'd0);
        @(posedge CLK); #1 Load_Done = 1'b0;
        @(negedge CLK);
        check("rerun_run", 32'(Run), 32'd1);
        check("rerun_fetch_gnt", 32'(Fetch_Gnt), 32'd1);
        @(posedge CLK); #1 Fetch_Req = 1'b0;
        @(negedge CLK);
        check("rerun_valid", 32'(Fetch_Valid), 32'd1);
        check("rerun_data", Fetch_Data, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
